// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_arb_pkg
// Purpose : Shared definitions for the FIFO write arbiter: arbiter state
//           encoding and default parameter values.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  // IDLE  : looking for a requester that fits in the FIFO
  // BURST : streaming beats from the granted requester
  // GAP   : one settling cycle so fifo_wr_count reflects the finished burst
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LSIZE = 5;
  localparam int DEF_CSIZE = 5;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker. Returns the first set bit of
//           vld, scanning upward from ptr and wrapping at NREQ.
// Ports   : vld   [NREQ]          request vector
//           ptr   [clog2(NREQ)]   highest-priority index
//           found                 any request present
//           idx   [clog2(NREQ)]   index of the winner (0 when !found)
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         vld,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDW = $clog2(NREQ);

  int             pos;
  logic [IDW-1:0] pos_idx;

  // Walk from the farthest offset down to ptr itself so the closest
  // requester (lowest offset) is the last to overwrite the result.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos     = (int'(ptr) + k) % NREQ;
      pos_idx = IDW'(pos);
      if (vld[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Purpose : Round-robin arbiter granting whole bursts from NREQ requesters
//           into one FIFO write port. A burst is granted only if the FIFO
//           has room for all of it, so a granted burst never overflows.
// Ports   : clk, rst                 clock, async active-high reset
//           req_vld  [NREQ]          per-requester request / beat valid
//           req_len  [NREQ*LSIZE]    burst length (0 means 1), sampled at grant
//           req_data [NREQ*DSIZE]    per-requester beat data
//           req_gnt  [NREQ]          one-hot grant, held for the burst
//           req_rdy  [NREQ]          one-hot beat-accept strobe
//           fifo_wr_en/fifo_wr_data  FIFO write port
//           fifo_wr_full/_count      FIFO write-side status
//           busy, cur_id             not-idle flag, granted requester index
// Rev     : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int NREQ  = DEF_NREQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LSIZE = DEF_LSIZE,
  parameter int CSIZE = DEF_CSIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*LSIZE-1:0]   req_len,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_gnt,
  output logic [NREQ-1:0]         req_rdy,
  output logic                    fifo_wr_en,
  output logic [DSIZE-1:0]        fifo_wr_data,
  input  logic                    fifo_wr_full,
  input  logic [CSIZE-1:0]        fifo_wr_count,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] cur_id
);

  localparam int             IDW     = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  arb_state_e       state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [IDW-1:0]   cur_id_q;
  logic [LSIZE-1:0] cnt_q;
  logic [LSIZE-1:0] cnt_d;
  logic [NREQ-1:0]  gnt_q;

  logic [LSIZE-1:0] len_arr  [NREQ];
  logic [DSIZE-1:0] data_arr [NREQ];

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [LSIZE-1:0] eff_len;
  int               free_words;
  logic             space_ok;
  logic             beat;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_arr[g]  = req_len[g*LSIZE +: LSIZE];
    assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .vld   (req_vld),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A zero length still moves one beat. A count above DEPTH means the
  // status is out of range, so treat the FIFO as having no room at all.
  always_comb begin
    eff_len    = (len_arr[pick_idx] == '0) ? LSIZE'(1) : len_arr[pick_idx];
    free_words = (int'(fifo_wr_count) > DEPTH) ? 0 : DEPTH - int'(fifo_wr_count);
    space_ok   = free_words >= int'(eff_len);
  end

  // Only the granted requester can move a beat; everyone else's valid is
  // ignored once a burst is in flight.
  assign beat  = (state_q == BURST) && req_vld[cur_id_q] && !fifo_wr_full;
  assign cnt_d = cnt_q - LSIZE'(1);
  assign ptr_d = (cur_id_q == LAST_ID) ? '0 : cur_id_q + IDW'(1);

  assign fifo_wr_en   = beat;
  assign req_rdy      = beat ? (NREQ'(1) << cur_id_q) : '0;
  assign fifo_wr_data = (state_q == BURST) ? data_arr[cur_id_q] : '0;
  assign req_gnt      = gnt_q;
  assign cur_id       = cur_id_q;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // If the round-robin winner does not fit we simply wait for it;
          // skipping to a smaller burst could starve large requesters.
          if (pick_found && space_ok) begin
            gnt_q    <= NREQ'(1) << pick_idx;
            cur_id_q <= pick_idx;
            cnt_q    <= eff_len;
            state_q  <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            if (cnt_q == LSIZE'(1)) begin
              state_q <= GAP;
              gnt_q   <= '0;
              ptr_q   <= ptr_d;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Purpose : Directed self-checking bench for fifo_wr_arbiter (defaults:
//           DSIZE=8, NREQ=4, DEPTH=16, LSIZE=5, CSIZE=5).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld;
  logic [19:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  req_gnt;
  logic [3:0]  req_rdy;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr_full;
  logic [4:0]  fifo_wr_count;
  logic        busy;
  logic [1:0]  cur_id;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;

  fifo_wr_arbiter #(
    .DSIZE (8),
    .NREQ  (4),
    .DEPTH (16),
    .LSIZE (5),
    .CSIZE (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld       (req_vld),
    .req_len       (req_len),
    .req_data      (req_data),
    .req_gnt       (req_gnt),
    .req_rdy       (req_rdy),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_full  (fifo_wr_full),
    .fifo_wr_count (fifo_wr_count),
    .busy          (busy),
    .cur_id        (cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write the FIFO would actually accept on this edge.
  always @(posedge clk) begin
    if (fifo_wr_en) wr_total++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    rst           = 1'b1;
    req_vld       = 4'b0;
    req_len       = 20'b0;
    fifo_wr_full  = 1'b0;
    fifo_wr_count = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int w1;
    int exp_id;
    logic done;

    rst           = 1'b1;
    req_vld       = 4'b0;
    req_len       = 20'b0;
    req_data      = 32'hDDCCBBAA;
    fifo_wr_full  = 1'b0;
    fifo_wr_count = 5'd0;
    repeat (2) @(negedge clk);

    // ---- reset state (data nonzero, so wr_data must be forced to 0) ----
    chk("rst_gnt",   32'(req_gnt),      32'h0);
    chk("rst_rdy",   32'(req_rdy),      32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en),   32'h0);
    chk("rst_data",  32'(fifo_wr_data), 32'h0);
    chk("rst_busy",  32'(busy),         32'h0);
    chk("rst_cur",   32'(cur_id),       32'h0);
    rst = 1'b0;

    // ---- single requester, len 4 ----
    @(negedge clk);
    req_vld  = 4'b0001;
    req_len  = {5'd0, 5'd0, 5'd0, 5'd4};
    req_data = 32'hDDCCBBA0;
    w0       = wr_total;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req_data[7:0] = 8'hA0 + 8'(b);
      #1;
      if (b == 0) chk("t1_gnt", 32'(req_gnt), 32'h1);
      chk("t1_wr_en", 32'(fifo_wr_en),   32'h1);
      chk("t1_rdy",   32'(req_rdy),      32'h1);
      chk("t1_data",  32'(fifo_wr_data), 32'hA0 + 32'(b));
    end
    @(negedge clk);
    req_vld = 4'b0;
    #1;
    chk("t1_gap_gnt",  32'(req_gnt),    32'h0);
    chk("t1_gap_busy", 32'(busy),       32'h1);
    chk("t1_gap_wr",   32'(fifo_wr_en), 32'h0);
    @(negedge clk);
    #1;
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_writes",    32'(wr_total - w0), 32'd4);

    // ---- fairness: all request, len 2, order 0,1,2,3,0 ----
    do_reset();
    req_len = {5'd2, 5'd2, 5'd2, 5'd2};
    req_vld = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      exp_id = b % 4;
      @(negedge clk);
      #1;
      chk("fair_cur", 32'(cur_id),  32'(exp_id));
      chk("fair_gnt", 32'(req_gnt), 32'h1 << exp_id);
      chk("fair_rdy", 32'(req_rdy), 32'h1 << exp_id);
      @(negedge clk);
      #1;
      chk("fair_beat2", 32'(fifo_wr_en), 32'h1);
      @(negedge clk);
      if (b == 4) req_vld = 4'b0;
      #1;
      chk("fair_gap", 32'({busy, req_gnt}), 32'h10);
      @(negedge clk);
      #1;
      chk("fair_idle", 32'(busy), 32'h0);
    end

    // ---- space check: winner 1 (len 3) does not fit, no bypass to 2 ----
    do_reset();
    req_len       = {5'd0, 5'd1, 5'd3, 5'd0};
    req_vld       = 4'b0110;
    fifo_wr_count = 5'd14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("space_nogrant", 32'({busy, req_gnt}), 32'h0);
    end
    fifo_wr_count = 5'd13;
    w0 = wr_total;
    @(negedge clk);
    #1;
    chk("space_gnt", 32'(req_gnt), 32'h2);
    chk("space_cur", 32'(cur_id),  32'h1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    req_vld = 4'b0;
    #1;
    chk("space_gap", 32'(req_gnt), 32'h0);
    @(negedge clk);
    chk("space_writes", 32'(wr_total - w0), 32'd3);

    // ---- stalls: 2 cycles without valid, 3 cycles full ----
    do_reset();
    req_len = {5'd0, 5'd0, 5'd0, 5'd6};
    req_vld = 4'b0001;
    w0      = wr_total;
    @(negedge clk);
    #1;
    chk("stall_beat1", 32'(fifo_wr_en), 32'h1);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      req_vld = 4'b0;
      #1;
      chk("stall_novld", 32'({fifo_wr_en, req_rdy, req_gnt}), 32'h001);
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      req_vld      = 4'b0001;
      fifo_wr_full = 1'b1;
      #1;
      chk("stall_full", 32'({fifo_wr_en, req_rdy, req_gnt}), 32'h001);
    end
    @(negedge clk);
    fifo_wr_full = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_gnt == 4'b0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    req_vld = 4'b0;
    chk("stall_timeout", 32'(done), 32'h1);
    @(negedge clk);
    chk("stall_writes", 32'(wr_total - w0), 32'd6);

    // ---- len 0 gives one write ----
    do_reset();
    req_len = 20'b0;
    req_vld = 4'b0001;
    w0      = wr_total;
    @(negedge clk);
    #1;
    chk("len0_beat", 32'({fifo_wr_en, req_gnt}), 32'h11);
    @(negedge clk);
    req_vld = 4'b0;
    #1;
    chk("len0_gap", 32'({fifo_wr_en, req_gnt}), 32'h00);
    @(negedge clk);
    chk("len0_writes", 32'(wr_total - w0), 32'd1);

    // ---- reset mid-burst (ptr advanced to 1 first) ----
    do_reset();
    req_len = {5'd0, 5'd8, 5'd0, 5'd1};
    req_vld = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_vld = 4'b0;
    @(negedge clk);
    req_vld = 4'b0101;
    @(negedge clk);
    #1;
    chk("abort_cur", 32'(cur_id), 32'h2);
    w0 = wr_total;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_gnt",   32'(req_gnt),      32'h0);
    chk("abort_rdy",   32'(req_rdy),      32'h0);
    chk("abort_wr",    32'(fifo_wr_en),   32'h0);
    chk("abort_data",  32'(fifo_wr_data), 32'h0);
    chk("abort_busy",  32'(busy),         32'h0);
    chk("abort_curid", 32'(cur_id),       32'h0);
    @(negedge clk);
    w1 = wr_total;
    chk("abort_writes", 32'(w1 - w0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_ptr_cur", 32'(cur_id),  32'h0);
    chk("abort_ptr_gnt", 32'(req_gnt), 32'h1);
    req_vld = 4'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
